// File: rtl/data_mem_if.sv
// Per-lane data-memory valid/ready bundle between the core load/store
// units (master) and the memory responder (slave).
interface data_mem_if #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4
);
  logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

  modport master (
    output consumer_read_valid, consumer_read_address,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready
  );

  modport slave (
    input  consumer_read_valid, consumer_read_address,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    output consumer_read_ready, consumer_read_data, consumer_write_ready
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: per-lane four-phase FSMs, round-robin arbitration
// onto one storage port with a fixed access latency.
module data_mem_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int LATENCY       = 2
) (
  input  logic      clk,
  input  logic      reset,
  data_mem_if.slave mem_if,
  output logic      busy
);
  localparam int LW    = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int DEPTH = 1 << ADDR_BITS;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PENDING = 2'd1;
  localparam logic [1:0] S_ACCESS  = 2'd2;
  localparam logic [1:0] S_ACK     = 2'd3;

  logic [1:0]                              lane_state [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0]                lane_wr;
  logic [NUM_CONSUMERS-1:0]                read_ready_r;
  logic [NUM_CONSUMERS-1:0]                write_ready_r;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] read_data_r;

  logic                 acc_active;
  logic [3:0]           acc_cnt;
  logic                 acc_wr;
  logic [ADDR_BITS-1:0] acc_addr;
  logic [DATA_BITS-1:0] acc_data;
  logic                 acc_done;

  logic [LW-1:0] rr_ptr;
  logic [LW-1:0] grant_lane;
  logic          grant_vld;
  logic          grant_fire;
  int            arb_idx;

  logic [DATA_BITS-1:0] mem [DEPTH];

  assign mem_if.consumer_read_ready  = read_ready_r;
  assign mem_if.consumer_write_ready = write_ready_r;
  assign mem_if.consumer_read_data   = read_data_r;

  // The port frees up on the completion edge, so a new grant can overlap it
  assign acc_done   = acc_active && (acc_cnt == 4'd0);
  assign grant_fire = grant_vld && (!acc_active || acc_done);

  // Busy whenever any lane has left IDLE
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      if (lane_state[i] != S_IDLE) busy = 1'b1;
    end
  end

  // Round-robin search over PENDING lanes starting at rr_ptr
  always_comb begin
    grant_vld  = 1'b0;
    grant_lane = '0;
    arb_idx    = 0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      arb_idx = (int'(rr_ptr) + k) % NUM_CONSUMERS;
      if (!grant_vld && lane_state[LW'(arb_idx)] == S_PENDING) begin
        grant_vld  = 1'b1;
        grant_lane = LW'(arb_idx);
      end
    end
  end

  // Access control: occupancy, latency countdown, op and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_active <= 1'b0;
      acc_cnt    <= '0;
      acc_wr     <= 1'b0;
      rr_ptr     <= '0;
    end else if (grant_fire) begin
      acc_active <= 1'b1;
      acc_cnt    <= 4'(LATENCY - 1);
      acc_wr     <= lane_wr[grant_lane];
      rr_ptr     <= (grant_lane == LW'(NUM_CONSUMERS - 1)) ? '0 : grant_lane + 1'b1;
    end else if (acc_active) begin
      if (acc_done) acc_active <= 1'b0;
      else          acc_cnt    <= acc_cnt - 4'd1;
    end
  end

  // Address and write data are only sampled on the grant edge
  always_ff @(posedge clk) begin
    if (grant_fire) begin
      acc_addr <= lane_wr[grant_lane] ? mem_if.consumer_write_address[grant_lane]
                                      : mem_if.consumer_read_address[grant_lane];
      acc_data <= mem_if.consumer_write_data[grant_lane];
    end
  end

  // Per-lane IDLE/PENDING/ACCESS/ACK handshake; read wins when both are raised
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CONSUMERS; i++) lane_state[i] <= S_IDLE;
      lane_wr       <= '0;
      read_ready_r  <= '0;
      write_ready_r <= '0;
      read_data_r   <= '0;
    end else begin
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        case (lane_state[i])
          S_IDLE: begin
            if (mem_if.consumer_read_valid[i] || mem_if.consumer_write_valid[i]) begin
              lane_state[i] <= S_PENDING;
              lane_wr[i]    <= !mem_if.consumer_read_valid[i];
            end
          end
          S_PENDING: begin
            if (grant_fire && grant_lane == LW'(i)) lane_state[i] <= S_ACCESS;
          end
          S_ACCESS: begin
            if (acc_done) begin
              lane_state[i] <= S_ACK;
              if (acc_wr) begin
                write_ready_r[i] <= 1'b1;
              end else begin
                read_ready_r[i] <= 1'b1;
                read_data_r[i]  <= mem[acc_addr];
              end
            end
          end
          default: begin
            if (lane_wr[i] ? !mem_if.consumer_write_valid[i] : !mem_if.consumer_read_valid[i]) begin
              lane_state[i]    <= S_IDLE;
              read_ready_r[i]  <= 1'b0;
              write_ready_r[i] <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  // Storage array; a write commits only on its completion edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
    end else if (acc_done && acc_wr) begin
      mem[acc_addr] <= acc_data;
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table, handshake corner sequences,
// and randomized multi-lane bursts against an array/round-robin model.
module tb_data_mem_responder;
  localparam int AB = 8, DB = 8, NC = 4, LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy;

  data_mem_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC)) bus ();

  data_mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .mem_if(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lane;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;  // write data, or expected read data
  } vec_t;

  vec_t       vecs[10];
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] model_mem[256];
  int         last_grant;
  int         g_done[4];
  logic [7:0] g_addr[4], g_data[4], g_rdat[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.consumer_read_valid    = '0;
    bus.consumer_read_address  = '0;
    bus.consumer_write_valid   = '0;
    bus.consumer_write_address = '0;
    bus.consumer_write_data    = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // One uncontended transaction: latency, read data, and handshake close
  task automatic single_txn(input int lane, input bit wr, input logic [7:0] addr,
                            input logic [7:0] data, input string name);
    int n;
    logic got;
    if (wr) begin
      bus.consumer_write_valid[lane]   = 1'b1;
      bus.consumer_write_address[lane] = addr;
      bus.consumer_write_data[lane]    = data;
    end else begin
      bus.consumer_read_valid[lane]   = 1'b1;
      bus.consumer_read_address[lane] = addr;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      got = wr ? bus.consumer_write_ready[lane] : bus.consumer_read_ready[lane];
    end
    check({name, "_lat"}, n, LAT + 2);
    if (!wr) check({name, "_data"}, bus.consumer_read_data[lane], data);
    bus.consumer_read_valid[lane]  = 1'b0;
    bus.consumer_write_valid[lane] = 1'b0;
    tick();
    check({name, "_close"}, {bus.consumer_read_ready[lane], bus.consumer_write_ready[lane]}, 0);
  endtask

  // Lanes in en raise requests together; record the edge each one completes
  task automatic run_group(input logic [3:0] en, input logic [3:0] wrm);
    int n;
    logic [3:0] pend;
    pend = en;
    for (int i = 0; i < 4; i++) begin
      g_done[i] = -1;
      g_rdat[i] = 8'h00;
      if (en[i]) begin
        if (wrm[i]) begin
          bus.consumer_write_valid[i]   = 1'b1;
          bus.consumer_write_address[i] = g_addr[i];
          bus.consumer_write_data[i]    = g_data[i];
        end else begin
          bus.consumer_read_valid[i]   = 1'b1;
          bus.consumer_read_address[i] = g_addr[i];
        end
      end
    end
    n = 0;
    while (pend != 4'b0 && n < 100) begin
      tick();
      n++;
      for (int i = 0; i < 4; i++) begin
        if (pend[i] && (wrm[i] ? bus.consumer_write_ready[i] : bus.consumer_read_ready[i])) begin
          g_done[i] = n;
          g_rdat[i] = bus.consumer_read_data[i];
          pend[i]   = 1'b0;
          bus.consumer_read_valid[i]  = 1'b0;
          bus.consumer_write_valid[i] = 1'b0;
        end
      end
    end
    clear_inputs();
    tick();
    tick();
  endtask

  initial begin
    int n, l1, pos;
    logic ok;
    logic [7:0] d1;
    logic [3:0] en, wrm;

    vecs[0] = '{0, 1'b1, 8'h10, 8'hA5};
    vecs[1] = '{0, 1'b0, 8'h10, 8'hA5};
    vecs[2] = '{1, 1'b0, 8'h10, 8'hA5};
    vecs[3] = '{2, 1'b1, 8'h10, 8'h3C};
    vecs[4] = '{3, 1'b0, 8'h10, 8'h3C};
    vecs[5] = '{1, 1'b0, 8'h99, 8'h00};
    vecs[6] = '{0, 1'b1, 8'h01, 8'h11};
    vecs[7] = '{1, 1'b1, 8'h02, 8'h22};
    vecs[8] = '{2, 1'b1, 8'h03, 8'h33};
    vecs[9] = '{3, 1'b1, 8'h04, 8'h44};

    do_reset();
    check("reset_ready", {bus.consumer_read_ready, bus.consumer_write_ready}, 0);
    check("reset_rdata", bus.consumer_read_data, 0);
    check("reset_busy", busy, 0);

    for (int i = 0; i < 10; i++)
      single_txn(vecs[i].lane, vecs[i].wr, vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));

    // All four lanes read together; last grant was lane 3 so order is 0..3
    for (int i = 0; i < 4; i++) g_addr[i] = 8'(i + 1);
    run_group(4'b1111, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("contend_edge%0d", i), g_done[i], LAT + 2 + i * LAT);
      check($sformatf("contend_data%0d", i), g_rdat[i], 8'h11 * (i + 1));
    end

    // Lane 1 completes, then lanes 0 and 2 race: lane 2 comes first
    g_addr[1] = 8'h02;
    run_group(4'b0010, 4'b0000);
    check("rr_lane1_data", g_rdat[1], 8'h22);
    g_addr[0] = 8'h01;
    g_addr[2] = 8'h03;
    run_group(4'b0101, 4'b0000);
    check("rr_lane2_edge", g_done[2], LAT + 2);
    check("rr_lane0_edge", g_done[0], 2 * LAT + 2);
    check("rr_lane0_data", g_rdat[0], 8'h11);

    // Lane 3 read and write together: read first, write after close
    bus.consumer_read_valid[3]    = 1'b1;
    bus.consumer_read_address[3]  = 8'h20;
    bus.consumer_write_valid[3]   = 1'b1;
    bus.consumer_write_address[3] = 8'h20;
    bus.consumer_write_data[3]    = 8'h7E;
    n = 0;
    while (!bus.consumer_read_ready[3] && n < 40) begin tick(); n++; end
    check("rw_read_lat", n, LAT + 2);
    check("rw_read_data", bus.consumer_read_data[3], 8'h00);
    check("rw_write_early", bus.consumer_write_ready[3], 0);
    bus.consumer_read_valid[3] = 1'b0;
    n = 0;
    while (!bus.consumer_write_ready[3] && n < 40) begin tick(); n++; end
    check("rw_write_lat", n, LAT + 3);
    check("rw_read_closed", bus.consumer_read_ready[3], 0);
    bus.consumer_write_valid[3] = 1'b0;
    tick();
    check("rw_write_close", bus.consumer_write_ready[3], 0);
    single_txn(3, 1'b0, 8'h20, 8'h7E, "rw_readback");

    // Lane 0 holds ACK for 10 cycles while lane 1 is served
    bus.consumer_read_valid[0]   = 1'b1;
    bus.consumer_read_address[0] = 8'h10;
    n = 0;
    while (!bus.consumer_read_ready[0] && n < 40) begin tick(); n++; end
    check("hold_lat", n, LAT + 2);
    bus.consumer_read_valid[1]   = 1'b1;
    bus.consumer_read_address[1] = 8'h02;
    ok = 1'b1;
    l1 = -1;
    d1 = 8'h00;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus.consumer_read_ready[0] !== 1'b1 || bus.consumer_read_data[0] !== 8'h3C) ok = 1'b0;
      if (l1 < 0 && bus.consumer_read_ready[1]) begin
        l1 = c;
        d1 = bus.consumer_read_data[1];
        bus.consumer_read_valid[1] = 1'b0;
      end
    end
    check("hold_stable", ok, 1);
    check("hold_other_lat", l1, LAT + 2);
    check("hold_other_data", d1, 8'h22);
    bus.consumer_read_valid[0] = 1'b0;
    tick();
    check("hold_close", bus.consumer_read_ready[0], 0);

    // Reset lands while lane 2's write is in ACCESS
    bus.consumer_write_valid[2]   = 1'b1;
    bus.consumer_write_address[2] = 8'h05;
    bus.consumer_write_data[2]    = 8'h55;
    tick();
    tick();
    check("midrst_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    check("midrst_ready", {bus.consumer_read_ready, bus.consumer_write_ready}, 0);
    check("midrst_rdata", bus.consumer_read_data, 0);
    check("midrst_busy", busy, 0);
    clear_inputs();
    tick();
    tick();
    reset = 1'b1;
    single_txn(2, 1'b0, 8'h05, 8'h00, "midrst_readback");

    // Randomized bursts against an array + round-robin order model
    do_reset();
    for (int a = 0; a < 256; a++) model_mem[a] = 8'h00;
    last_grant = -1;
    for (int b = 0; b < 25; b++) begin
      en  = 4'($urandom_range(1, 15));
      wrm = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        g_addr[i] = {6'($urandom), 2'(i)};
        g_data[i] = 8'($urandom);
      end
      run_group(en, wrm);
      pos = 0;
      for (int k = 1; k <= 4; k++) begin
        int ln;
        ln = (last_grant + k) % 4;
        if (en[ln]) begin
          check($sformatf("rand%0d_edge_l%0d", b, ln), g_done[ln], LAT + 2 + pos * LAT);
          if (!wrm[ln]) check($sformatf("rand%0d_data_l%0d", b, ln), g_rdat[ln], model_mem[g_addr[ln]]);
          pos++;
        end
      end
      for (int k = 1; k <= 4; k++) begin
        int ln;
        ln = (last_grant + k) % 4;
        if (en[ln] && k > 0) begin
          if (wrm[ln]) model_mem[g_addr[ln]] = g_data[ln];
        end
      end
      for (int k = 4; k >= 1; k--) begin
        if (en[(last_grant + k) % 4]) begin
          last_grant = (last_grant + k) % 4;
          break;
        end
      end
      check($sformatf("rand%0d_idle", b), busy, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
